// File: rtl/psg_pkg.sv
// -----------------------------------------------------------------------------
// psg_pkg
//   Shared types, the YM log volume table and register-map helpers for the
//   multi-channel PSG (psg_multi and psg_tone_ch).
//   Optional feature macro: PSG_STEREO_EN (adds the PAN register to the map).
// -----------------------------------------------------------------------------
package psg_pkg;

    typedef enum logic [1:0] {
        ENV_DOWN,
        ENV_UP,
        ENV_HOLD
    } env_state_t;

    // 5-bit volume index to 8-bit DAC level, logarithmic YM-style curve.
    localparam logic [7:0] VOL_YM [32] = '{
        8'd0,   8'd1,   8'd1,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
        8'd5,   8'd6,   8'd7,   8'd8,   8'd9,   8'd11,  8'd13,  8'd16,
        8'd19,  8'd22,  8'd26,  8'd31,  8'd37,  8'd44,  8'd52,  8'd62,
        8'd74,  8'd88,  8'd104, 8'd124, 8'd147, 8'd175, 8'd208, 8'd255
    };

    // Register map: tone lo/hi pairs, noise, mixer, volumes, envelope, [pan].
    function automatic int reg_noise(input int nch);
        return 2 * nch;
    endfunction

    function automatic int reg_mixer(input int nch);
        return 2 * nch + 1;
    endfunction

    function automatic int reg_vol(input int nch);
        return 2 * nch + 2;
    endfunction

    // ENV_LO at this offset, ENV_HI at +1, ENV_SHAPE at +2.
    function automatic int reg_env(input int nch);
        return 3 * nch + 2;
    endfunction

    function automatic int reg_pan(input int nch);
        return 3 * nch + 5;
    endfunction

    function automatic int map_size(input int nch);
`ifdef PSG_STEREO_EN
        return 3 * nch + 6;
`else
        return 3 * nch + 5;
`endif
    endfunction

endpackage

// File: rtl/psg_tone_ch.sv
// -----------------------------------------------------------------------------
// psg_tone_ch
//   One PSG channel: tone period counter, square output, tone/noise gate and
//   volume select through the log table.
//   Ports:
//     clk_i, rst_ni   clock, async active-low reset
//     period_i        tone period (0 behaves as 1)
//     tick_i          tone tick from the shared prescaler
//     tone_off_i      mixer tone-disable bit for this channel
//     noise_off_i     mixer noise-disable bit for this channel
//     vol_i           [4] envelope mode, [3:0] fixed level
//     env_vol_i       shared envelope volume
//     lfsr0_i         noise bit
//     level_o         combinational DAC level (registered by the top)
// -----------------------------------------------------------------------------
module psg_tone_ch
    import psg_pkg::*;
#(
    parameter int TONE_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [TONE_W-1:0] period_i,
    input  logic              tick_i,
    input  logic              tone_off_i,
    input  logic              noise_off_i,
    input  logic [4:0]        vol_i,
    input  logic [4:0]        env_vol_i,
    input  logic              lfsr0_i,
    output logic [7:0]        level_o
);

    logic [TONE_W-1:0] cnt_q, cnt_d, per_m1;
    logic              sq_q, sq_d;
    logic              gate_on;
    logic [4:0]        vol_idx;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        sq_d  = sq_q;
        per_m1 = (period_i == '0) ? '0 : period_i - TONE_W'(1);
        if (tick_i) begin
            // ">=" rather than "==": a period lowered below the current count
            // wraps on the next tick instead of running out to the top.
            if (cnt_q >= per_m1) begin
                cnt_d = '0;
                sq_d  = ~sq_q;
            end else begin
                cnt_d = cnt_q + TONE_W'(1);
            end
        end
        gate_on = (tone_off_i | sq_q) & (noise_off_i | lfsr0_i);
        vol_idx = vol_i[4] ? env_vol_i : {vol_i[3:0], vol_i[3]};
        level_o = gate_on ? VOL_YM[vol_idx] : 8'h00;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state is updated with <= so every register samples pre-edge values.
        if (!rst_ni) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
        end
    end

endmodule

// File: rtl/psg_multi.sv
// -----------------------------------------------------------------------------
// psg_multi
//   NCH-channel AY-style PSG with shared noise LFSR and envelope, per-channel
//   log DAC levels, a registered summed MIX output and optional stereo pan.
//   Optional feature macro: PSG_STEREO_EN (PAN register, L_OUT/R_OUT ports).
//   Ports:
//     CLK, RESET_N    clock, async active-low reset
//     CE              PSG clock enable (prescaler, tone, noise, envelope)
//     BDIR, BC, DI    bus: BDIR rising edge takes a cycle; BC=1 address, 0 data
//     DO              readback of the addressed register, 0 past the map
//     LEVEL           per-channel DAC level, ch0 in [7:0] (registered)
//     MIX             sum of all LEVEL channels (registered)
//     L_OUT, R_OUT    [PSG_STEREO_EN] panned left/right sums (registered)
// -----------------------------------------------------------------------------
module psg_multi
    import psg_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int TONE_W = 12,
    parameter int PRESC  = 8
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        CE,
    input  logic                        BDIR,
    input  logic                        BC,
    input  logic [7:0]                  DI,
    output logic [7:0]                  DO,
    output logic [8*NCH-1:0]            LEVEL,
    output logic [8+$clog2(NCH+1)-1:0]  MIX
`ifdef PSG_STEREO_EN
    ,
    output logic [9:0]                  L_OUT,
    output logic [9:0]                  R_OUT
`endif
);

    localparam int MAP     = map_size(NCH);
    localparam int AW      = $clog2(MAP);
    localparam int MW      = 8 + $clog2(NCH + 1);
    localparam int PW      = $clog2(PRESC);
    localparam int R_NOISE = reg_noise(NCH);
    localparam int R_MIXER = reg_mixer(NCH);
    localparam int R_VOL   = reg_vol(NCH);
    localparam int R_ENV   = reg_env(NCH);

    // ---------------- bus and register file ----------------
    logic              bdir_q;
    logic [AW-1:0]     addr_q;
    logic [TONE_W-1:0] tone_per_q [NCH];
    logic [4:0]        vol_q      [NCH];
    logic [4:0]        noise_per_q;
    logic [7:0]        mixer_q;
    logic [15:0]       env_per_q;
    logic [3:0]        shape_q;
`ifdef PSG_STEREO_EN
    logic [2*NCH-1:0]  pan_q;
`endif
    logic              bus_cyc, wr, wr_shape;

    assign bus_cyc  = BDIR & ~bdir_q;
    assign wr       = bus_cyc & ~BC;
    assign wr_shape = wr && (addr_q == AW'(R_ENV + 2));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bdir_q      <= 1'b0;
            addr_q      <= '0;
            // NOTE: the small register file is reset in full because every field has a defined reset value.
            for (int i = 0; i < NCH; i++) begin
                tone_per_q[i] <= '0;
                vol_q[i]      <= '0;
            end
            noise_per_q <= '0;
            mixer_q     <= 8'hFF;
            env_per_q   <= '0;
            shape_q     <= '0;
`ifdef PSG_STEREO_EN
            pan_q       <= '1;
`endif
        end else begin
            bdir_q <= BDIR;
            if (bus_cyc && BC) addr_q <= DI[AW-1:0];
            if (wr) begin
                for (int i = 0; i < NCH; i++) begin
                    if (addr_q == AW'(2 * i))     tone_per_q[i][7:0]        <= DI;
                    if (addr_q == AW'(2 * i + 1)) tone_per_q[i][TONE_W-1:8] <= DI[TONE_W-9:0];
                    if (addr_q == AW'(R_VOL + i)) vol_q[i]                  <= DI[4:0];
                end
                if (addr_q == AW'(R_NOISE))   noise_per_q     <= DI[4:0];
                if (addr_q == AW'(R_MIXER))   mixer_q         <= DI;
                if (addr_q == AW'(R_ENV))     env_per_q[7:0]  <= DI;
                if (addr_q == AW'(R_ENV + 1)) env_per_q[15:8] <= DI;
                if (wr_shape)                 shape_q         <= DI[3:0];
`ifdef PSG_STEREO_EN
                if (addr_q == AW'(reg_pan(NCH))) pan_q <= DI[2*NCH-1:0];
`endif
            end
        end
    end

    always_comb begin
        DO = 8'h00;
        for (int i = 0; i < NCH; i++) begin
            if (addr_q == AW'(2 * i))     DO = tone_per_q[i][7:0];
            if (addr_q == AW'(2 * i + 1)) DO = 8'(tone_per_q[i][TONE_W-1:8]);
            if (addr_q == AW'(R_VOL + i)) DO = {3'b000, vol_q[i]};
        end
        if (addr_q == AW'(R_NOISE))   DO = {3'b000, noise_per_q};
        if (addr_q == AW'(R_MIXER))   DO = mixer_q;
        if (addr_q == AW'(R_ENV))     DO = env_per_q[7:0];
        if (addr_q == AW'(R_ENV + 1)) DO = env_per_q[15:8];
        if (addr_q == AW'(R_ENV + 2)) DO = {4'h0, shape_q};
`ifdef PSG_STEREO_EN
        if (addr_q == AW'(reg_pan(NCH))) DO = 8'(pan_q);
`endif
    end

    // ---------------- prescaler, noise, envelope timing ----------------
    logic [PW-1:0] presc_q, presc_d;
    logic          ndiv_q, ndiv_d;
    logic [4:0]    ncnt_q, ncnt_d, noise_per_m1;
    logic [16:0]   lfsr_q, lfsr_d;
    logic [15:0]   env_cnt_q, env_cnt_d, env_per_m1;
    logic          tone_tick, noise_tick, env_tick;

    always_comb begin
        presc_d    = presc_q;
        ndiv_d     = ndiv_q;
        ncnt_d     = ncnt_q;
        lfsr_d     = lfsr_q;
        env_cnt_d  = env_cnt_q;
        env_tick   = 1'b0;
        tone_tick  = CE && (presc_q == '0);
        noise_tick = tone_tick && ndiv_q;
        noise_per_m1 = (noise_per_q == '0) ? '0 : noise_per_q - 5'd1;
        env_per_m1   = (env_per_q == '0) ? '0 : env_per_q - 16'd1;
        if (CE) presc_d = (presc_q == '0) ? PW'(PRESC - 1) : presc_q - PW'(1);
        if (tone_tick) begin
            ndiv_d = ~ndiv_q;
            if (env_cnt_q >= env_per_m1) begin
                env_cnt_d = '0;
                env_tick  = 1'b1;
            end else begin
                env_cnt_d = env_cnt_q + 16'd1;
            end
        end
        if (noise_tick) begin
            if (ncnt_q >= noise_per_m1) begin
                ncnt_d = '0;
                lfsr_d = (lfsr_q == '0) ? 17'h1 : {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
            end else begin
                ncnt_d = ncnt_q + 5'd1;
            end
        end
    end

    // ---------------- envelope FSM ----------------
    env_state_t env_state_q, env_state_d;
    logic [4:0] env_vol_q, env_vol_d;
    logic       restart_q, restart_d;
    logic       sh_c, sh_at, sh_al, sh_h, at_end, going_up;

    assign {sh_c, sh_at, sh_al, sh_h} = shape_q;

    always_comb begin
        env_state_d = env_state_q;
        env_vol_d   = env_vol_q;
        // A shape write arms restart; it is consumed by the first later CE.
        restart_d   = wr_shape ? 1'b1 : (CE ? 1'b0 : restart_q);
        going_up    = (env_state_q == ENV_UP);
        at_end      = (going_up && env_vol_q == 5'd31) ||
                      (env_state_q == ENV_DOWN && env_vol_q == 5'd0);
        if (CE && restart_q) begin
            env_state_d = sh_at ? ENV_UP : ENV_DOWN;
            env_vol_d   = sh_at ? 5'd0 : 5'd31;
        end else if (env_tick && env_state_q != ENV_HOLD) begin
            if (at_end) begin
                if (!sh_c) begin
                    env_state_d = ENV_HOLD;
                    env_vol_d   = 5'd0;
                end else if (sh_h) begin
                    env_state_d = ENV_HOLD;
                    env_vol_d   = env_vol_q ^ {5{sh_al}};
                end else if (sh_al) begin
                    env_state_d = going_up ? ENV_DOWN : ENV_UP;
                end else begin
                    env_vol_d   = ~env_vol_q;
                end
            end else begin
                env_vol_d = going_up ? env_vol_q + 5'd1 : env_vol_q - 5'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q     <= '0;
            ndiv_q      <= 1'b0;
            ncnt_q      <= '0;
            lfsr_q      <= 17'h1;
            env_cnt_q   <= '0;
            env_state_q <= ENV_HOLD;
            env_vol_q   <= '0;
            restart_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            ndiv_q      <= ndiv_d;
            ncnt_q      <= ncnt_d;
            lfsr_q      <= lfsr_d;
            env_cnt_q   <= env_cnt_d;
            env_state_q <= env_state_d;
            env_vol_q   <= env_vol_d;
            restart_q   <= restart_d;
        end
    end

    // ---------------- channels and output registers ----------------
    logic [7:0] lvl [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        psg_tone_ch #(.TONE_W(TONE_W)) u_ch (
            .clk_i      (CLK),
            .rst_ni     (RESET_N),
            .period_i   (tone_per_q[g]),
            .tick_i     (tone_tick),
            .tone_off_i (mixer_q[g]),
            .noise_off_i(mixer_q[4+g]),
            .vol_i      (vol_q[g]),
            .env_vol_i  (env_vol_q),
            .lfsr0_i    (lfsr_q[0]),
            .level_o    (lvl[g])
        );
    end

    logic [8*NCH-1:0] level_q, level_d;
    logic [MW-1:0]    mix_q, mix_d;
`ifdef PSG_STEREO_EN
    logic [9:0]       l_q, l_d, r_q, r_d;
`endif

    always_comb begin
        level_d = '0;
        mix_d   = '0;
`ifdef PSG_STEREO_EN
        l_d = '0;
        r_d = '0;
`endif
        for (int i = 0; i < NCH; i++) begin
            level_d[8*i +: 8] = lvl[i];
            mix_d = mix_d + MW'(lvl[i]);
`ifdef PSG_STEREO_EN
            if (pan_q[2*i])     l_d = l_d + 10'(lvl[i]);
            if (pan_q[2*i + 1]) r_d = r_d + 10'(lvl[i]);
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            level_q <= '0;
            mix_q   <= '0;
`ifdef PSG_STEREO_EN
            l_q     <= '0;
            r_q     <= '0;
`endif
        end else begin
            level_q <= level_d;
            mix_q   <= mix_d;
`ifdef PSG_STEREO_EN
            l_q     <= l_d;
            r_q     <= r_d;
`endif
        end
    end

    assign LEVEL = level_q;
    assign MIX   = mix_q;
`ifdef PSG_STEREO_EN
    assign L_OUT = l_q;
    assign R_OUT = r_q;
`endif

endmodule

// File: tb/tb_psg_multi.sv
`timescale 1ns/1ps
module tb_psg_multi;

`ifdef PSG_STEREO_EN
    localparam int N = 4;
`else
    localparam int N = 3;
`endif
    localparam int PRESC   = 8;
    localparam int MW      = 8 + $clog2(N + 1);
    localparam int A_NOISE = 2 * N;
    localparam int A_MIXER = 2 * N + 1;
    localparam int A_VOL   = 2 * N + 2;
    localparam int A_ENV   = 3 * N + 2;
    localparam int A_SHAPE = 3 * N + 4;
`ifdef PSG_STEREO_EN
    localparam int A_PAN   = 3 * N + 5;
    localparam int A_PAST  = 3 * N + 6;
`else
    localparam int A_PAST  = 3 * N + 5;
`endif

    localparam logic [7:0] YM [32] = '{
        8'd0,   8'd1,   8'd1,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
        8'd5,   8'd6,   8'd7,   8'd8,   8'd9,   8'd11,  8'd13,  8'd16,
        8'd19,  8'd22,  8'd26,  8'd31,  8'd37,  8'd44,  8'd52,  8'd62,
        8'd74,  8'd88,  8'd104, 8'd124, 8'd147, 8'd175, 8'd208, 8'd255
    };

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             CE = 1'b0;
    logic             BDIR = 1'b0;
    logic             BC = 1'b0;
    logic [7:0]       DI = 8'h00;
    logic [7:0]       DO;
    logic [8*N-1:0]   LEVEL;
    logic [MW-1:0]    MIX;
`ifdef PSG_STEREO_EN
    logic [9:0]       L_OUT, R_OUT;
`endif

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    psg_multi #(.NCH(N), .TONE_W(12), .PRESC(PRESC)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .CE     (CE),
        .BDIR   (BDIR),
        .BC     (BC),
        .DI     (DI),
        .DO     (DO),
        .LEVEL  (LEVEL),
        .MIX    (MIX)
`ifdef PSG_STEREO_EN
        ,
        .L_OUT  (L_OUT),
        .R_OUT  (R_OUT)
`endif
    );

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        RESET_N = 1'b0; CE = 1'b0; BDIR = 1'b0; BC = 1'b0; DI = 8'h00;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic set_addr(input logic [7:0] a);
        @(negedge CLK); BC = 1'b1; DI = a; BDIR = 1'b1;
        @(negedge CLK); BDIR = 1'b0;
        @(negedge CLK); BC = 1'b0;
    endtask

    // Leaves the address latch pointing at a.
    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        set_addr(a);
        DI = d; BDIR = 1'b1;
        @(negedge CLK); BDIR = 1'b0;
        @(negedge CLK);
    endtask

    // n single-cycle CE pulses, then one spare cycle so LEVEL/MIX have settled.
    task automatic ce_pulse(input int n);
        repeat (n) begin
            @(negedge CLK); CE = 1'b1;
            @(negedge CLK); CE = 1'b0;
        end
        @(negedge CLK);
    endtask

    // Hand-derived envelope volume after t env ticks (t = 0 is the restart CE).
    function automatic int env_exp(input logic [3:0] s, input int t);
        case (s)
            4'hE:    return (t <= 31) ? t : (t <= 63) ? 63 - t : t - 64;
            4'h9:    return (t <= 31) ? 31 - t : 0;
            4'hB:    return (t <= 31) ? 31 - t : 31;
            default: return 0;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if (LEVEL !== '0) $display("FAIL reset LEVEL: got %h want 0", LEVEL); else passed++;
        total++;
        if (MIX !== '0) $display("FAIL reset MIX: got %0d want 0", MIX); else passed++;
        total++;
        if (DO !== 8'h00) $display("FAIL reset DO: got %h want 00", DO); else passed++;
        set_addr(8'(A_MIXER));
        total++;
        if (DO !== 8'hFF) $display("FAIL reset mixer DO: got %h want ff", DO); else passed++;
    endtask

    task automatic test_readback();
        logic [7:0] addr [7];
        logic [7:0] data [7];
        logic [7:0] want [7];
        addr = '{8'd1,  8'(A_NOISE), 8'(A_VOL), 8'(A_ENV + 1), 8'(A_SHAPE), 8'(A_PAST), 8'd0};
        data = '{8'hFF, 8'hFF,       8'hFF,     8'hAB,         8'hFF,       8'h55,      8'hC3};
        want = '{8'h0F, 8'h1F,       8'h1F,     8'hAB,         8'h0F,       8'h00,      8'hC3};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bus_wr(addr[i], data[i]);
            total++;
            if (DO !== want[i])
                $display("FAIL readback addr %0d: got %h want %h", addr[i], DO, want[i]);
            else passed++;
        end
    endtask

    task automatic test_tone(input logic [7:0] per_lo);
        logic [7:0] exp;
        do_reset();
        bus_wr(8'd0, per_lo);
        bus_wr(8'(A_MIXER), 8'hFE);
        bus_wr(8'(A_VOL), 8'h0F);
        total++;
        if (LEVEL[7:0] !== 8'h00) $display("FAIL tone%0d idle: got %h want 00", per_lo, LEVEL[7:0]);
        else passed++;
        for (int t = 0; t < 4; t++) begin
            exp = (t % 2 == 0) ? 8'hFF : 8'h00;
            ce_pulse(1);
            total++;
            if (LEVEL[7:0] !== exp || MIX !== MW'(exp))
                $display("FAIL tone%0d tick %0d: got LEVEL %h MIX %0d want %h", per_lo, t, LEVEL[7:0], MIX, exp);
            else passed++;
            ce_pulse(PRESC - 1);
            total++;
            if (LEVEL[7:0] !== exp)
                $display("FAIL tone%0d hold %0d: got %h want %h", per_lo, t, LEVEL[7:0], exp);
            else passed++;
        end
    endtask

    // Lower the period below/at the running count: must wrap at the next tick.
    task automatic test_period_lower(input int ticks, input logic [7:0] new_lo);
        do_reset();
        bus_wr(8'd0, 8'h00);
        bus_wr(8'd1, 8'h01);
        bus_wr(8'(A_MIXER), 8'hFE);
        bus_wr(8'(A_VOL), 8'h0F);
        ce_pulse(1 + (ticks - 1) * PRESC);
        bus_wr(8'd1, 8'h00);
        bus_wr(8'd0, new_lo);
        total++;
        if (LEVEL[7:0] !== 8'h00) $display("FAIL lower cnt%0d before: got %h want 00", ticks, LEVEL[7:0]);
        else passed++;
        ce_pulse(PRESC);
        total++;
        if (LEVEL[7:0] !== 8'hFF) $display("FAIL lower cnt%0d wrap: got %h want ff", ticks, LEVEL[7:0]);
        else passed++;
    endtask

    task automatic test_noise();
        do_reset();
        bus_wr(8'(A_MIXER), 8'hEF);
        bus_wr(8'(A_VOL), 8'h0F);
        total++;
        if (LEVEL[7:0] !== 8'hFF) $display("FAIL noise seed: got %h want ff", LEVEL[7:0]); else passed++;
        ce_pulse(1);
        total++;
        if (LEVEL[7:0] !== 8'hFF) $display("FAIL noise first tick: got %h want ff", LEVEL[7:0]); else passed++;
        ce_pulse(PRESC);
        total++;
        if (LEVEL[7:0] !== 8'h00 || MIX !== '0)
            $display("FAIL noise shift: got LEVEL %h MIX %0d want 00", LEVEL[7:0], MIX);
        else passed++;
    endtask

    task automatic test_env_shape(input logic [3:0] shape, input int nticks);
        int exp;
        do_reset();
        bus_wr(8'(A_ENV), 8'h01);
        bus_wr(8'(A_VOL), 8'h10);
        bus_wr(8'(A_SHAPE), {4'h0, shape});
        for (int t = 0; t < nticks; t++) begin
            ce_pulse(1);
            exp = env_exp(shape, t);
            total++;
            if (LEVEL[7:0] !== YM[exp])
                $display("FAIL env %h tick %0d: got %h want %h (vol %0d)", shape, t, LEVEL[7:0], YM[exp], exp);
            else passed++;
            ce_pulse(PRESC - 1);
        end
    endtask

    task automatic test_restart();
        do_reset();
        bus_wr(8'(A_ENV), 8'h01);
        bus_wr(8'(A_VOL), 8'h10);
        bus_wr(8'(A_SHAPE), 8'h0C);
        ce_pulse(1 + 10 * PRESC);            // CE #81: vol 10
        ce_pulse(3);                         // CE #84, no tick
        total++;
        if (LEVEL[7:0] !== YM[10]) $display("FAIL restart ramp: got %h want %h", LEVEL[7:0], YM[10]);
        else passed++;
        bus_wr(8'(A_SHAPE), 8'h0C);
        ce_pulse(1);                         // CE #85: restart mid-ramp
        total++;
        if (LEVEL[7:0] !== YM[0]) $display("FAIL restart mid: got %h want %h", LEVEL[7:0], YM[0]);
        else passed++;
        ce_pulse(4);                         // CE #89 tick: vol 1
        total++;
        if (LEVEL[7:0] !== YM[1]) $display("FAIL restart resume: got %h want %h", LEVEL[7:0], YM[1]);
        else passed++;
        ce_pulse(7);                         // CE #96
        bus_wr(8'(A_SHAPE), 8'h0C);
        ce_pulse(1);                         // CE #97: restart and env tick together
        total++;
        if (LEVEL[7:0] !== YM[0]) $display("FAIL restart on tick: got %h want %h", LEVEL[7:0], YM[0]);
        else passed++;
        ce_pulse(PRESC);                     // CE #105: vol 1
        total++;
        if (LEVEL[7:0] !== YM[1]) $display("FAIL restart after tick: got %h want %h", LEVEL[7:0], YM[1]);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus_wr(8'(A_VOL), 8'h0F);
        bus_wr(8'(A_MIXER), 8'hFF);
        total++;
        if (LEVEL[7:0] !== 8'hFF || MIX !== MW'(255) || DO !== 8'hFF)
            $display("FAIL areset pre: got LEVEL %h MIX %0d DO %h want ff 255 ff", LEVEL[7:0], MIX, DO);
        else passed++;
`ifdef PSG_STEREO_EN
        total++;
        if (L_OUT !== 10'd255 || R_OUT !== 10'd255)
            $display("FAIL areset pre pan: got L %0d R %0d want 255 255", L_OUT, R_OUT);
        else passed++;
`endif
        @(negedge CLK);
        #1 RESET_N = 1'b0;
        #1;
        total++;
        if (LEVEL !== '0 || MIX !== '0 || DO !== 8'h00)
            $display("FAIL areset: got LEVEL %h MIX %0d DO %h want 0", LEVEL, MIX, DO);
        else passed++;
`ifdef PSG_STEREO_EN
        total++;
        if (L_OUT !== '0 || R_OUT !== '0)
            $display("FAIL areset pan: got L %0d R %0d want 0 0", L_OUT, R_OUT);
        else passed++;
`endif
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

`ifdef PSG_STEREO_EN
    task automatic test_stereo();
        do_reset();
        set_addr(8'(A_PAN));
        total++;
        if (DO !== 8'hFF) $display("FAIL pan reset: got %h want ff", DO); else passed++;
        for (int i = 0; i < N; i++) bus_wr(8'(A_VOL + i), 8'h0F);
        bus_wr(8'(A_PAN), 8'b10_01_11_00);
        @(negedge CLK);
        total++;
        if (L_OUT !== 10'd510) $display("FAIL stereo L: got %0d want 510", L_OUT); else passed++;
        total++;
        if (R_OUT !== 10'd510) $display("FAIL stereo R: got %0d want 510", R_OUT); else passed++;
        // MIX sums every channel regardless of pan.
        total++;
        if (MIX !== MW'(1020)) $display("FAIL stereo MIX: got %0d want 1020", MIX); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_readback();
        test_tone(8'h01);
        test_tone(8'h00);
        test_period_lower(3, 8'h04);
        test_period_lower(5, 8'h02);
        test_noise();
        test_env_shape(4'hE, 70);
        test_env_shape(4'h9, 41);
        test_env_shape(4'hB, 41);
        test_restart();
`ifdef PSG_STEREO_EN
        test_stereo();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
